// File: rtl/mem_loader_pkg.sv
// Shared command codes, error codes, FSM states and the frame range check for mem_loader.
package mem_loader_pkg;

  localparam logic [7:0] CmdImem = 8'h01;
  localparam logic [7:0] CmdDmem = 8'h02;
  localparam logic [7:0] CmdRun  = 8'h03;

  typedef enum logic [1:0] {
    ErrNone  = 2'd0,
    ErrCmd   = 2'd1,
    ErrRange = 2'd2,
    ErrCsum  = 2'd3
  } err_code_e;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StCount,
    StData,
    StCsum,
    StDone,
    StErr
  } state_e;

  // True when words [addr, addr+count) all fit in a memory of the given depth.
  // The high address bits must be zero first, so the wide sum can never wrap.
  function automatic logic range_ok(input logic [31:0] addr, input logic [15:0] count,
                                    input int unsigned addr_width, input int unsigned depth);
    logic [32:0] last;
    logic [32:0] lim;
    if ((addr >> addr_width) != 32'd0) begin
      return 1'b0;
    end
    last = {1'b0, addr} + {17'd0, count};
    lim  = 33'(depth);
    return last <= lim;
  endfunction

endpackage

// File: rtl/mem_loader_word_assembler.sv
// Packs data bytes LSB-first into 32-bit words, pulses word_done the cycle after the 4th byte
// and keeps a running XOR of every byte seen since the last clear.
module mem_loader_word_assembler (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        clear_i,
  input  logic        valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic [1:0]  byte_cnt_o,
  output logic        word_done_o,
  output logic [7:0]  csum_o
);

  logic [31:0] shift_q, shift_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic [7:0]  csum_q, csum_d;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    csum_d  = csum_q;
    if (clear_i) begin
      shift_d = '0;
      cnt_d   = '0;
      csum_d  = '0;
    end else if (valid_i) begin
      shift_d = {byte_i, shift_q[31:8]};
      cnt_d   = cnt_q + 2'd1;
      done_d  = (cnt_q == 2'd3);
      csum_d  = csum_q ^ byte_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      shift_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      csum_q  <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      csum_q  <= csum_d;
    end
  end

  assign word_o      = shift_q;
  assign byte_cnt_o  = cnt_q;
  assign word_done_o = done_q;
  assign csum_o      = csum_q;

endmodule

// File: rtl/mem_loader.sv
// Framed byte-stream loader: writes 32-bit words into imem/dmem and releases the core on RUN.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 15,
  parameter int unsigned IMEM_WORDS = 32768,
  parameter int unsigned DMEM_WORDS = 32768
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  rx_valid_i,
  input  logic [7:0]            rx_data_i,
  output logic                  rx_ready_o,
  output logic                  mem_we_o,
  output logic                  mem_sel_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  output logic                  cpu_run_o,
  output logic                  busy_o,
  output logic                  err_o,
  output logic [1:0]            err_code_o
);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] count_q, count_d;
  logic [1:0]  field_cnt_q, field_cnt_d;
  logic [15:0] word_idx_q, word_idx_d;
  logic        sel_q, sel_d;
  logic        err_q, err_d;
  err_code_e   err_code_q, err_code_d;
  logic        run_q, run_d;

  logic        accept;
  logic        asm_clear, asm_valid;
  logic [31:0] asm_word;
  logic [1:0]  asm_byte_cnt;
  logic        asm_word_done;
  logic [7:0]  asm_csum;
  logic [15:0] full_count;
  int unsigned depth_sel;

  mem_loader_word_assembler u_word_asm (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .clear_i     (asm_clear),
    .valid_i     (asm_valid),
    .byte_i      (rx_data_i),
    .word_o      (asm_word),
    .byte_cnt_o  (asm_byte_cnt),
    .word_done_o (asm_word_done),
    .csum_o      (asm_csum)
  );

  assign rx_ready_o = (state_q != StDone) && (state_q != StErr);
  assign accept     = rx_valid_i && rx_ready_o;
  assign full_count = {rx_data_i, count_q[15:8]};
  assign depth_sel  = sel_q ? DMEM_WORDS : IMEM_WORDS;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    count_d     = count_q;
    field_cnt_d = field_cnt_q;
    word_idx_d  = word_idx_q;
    sel_d       = sel_q;
    err_d       = err_q;
    err_code_d  = err_code_q;
    run_d       = run_q;
    asm_clear   = 1'b0;
    asm_valid   = 1'b0;

    if (asm_word_done) begin
      word_idx_d = word_idx_q + 16'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          unique case (rx_data_i)
            CmdImem, CmdDmem: begin
              sel_d       = (rx_data_i == CmdDmem);
              addr_d      = '0;
              count_d     = '0;
              field_cnt_d = '0;
              word_idx_d  = '0;
              asm_clear   = 1'b1;
              state_d     = StAddr;
            end
            CmdRun: begin
              run_d   = !err_q;
              state_d = StDone;
            end
            default: begin
              err_d      = 1'b1;
              err_code_d = ErrCmd;
              state_d    = StErr;
            end
          endcase
        end
      end
      StAddr: begin
        if (accept) begin
          addr_d      = {rx_data_i, addr_q[31:8]};
          field_cnt_d = field_cnt_q + 2'd1;
          if (field_cnt_q == 2'd3) begin
            field_cnt_d = '0;
            state_d     = StCount;
          end
        end
      end
      StCount: begin
        if (accept) begin
          count_d     = full_count;
          field_cnt_d = field_cnt_q + 2'd1;
          if (field_cnt_q == 2'd1) begin
            field_cnt_d = '0;
            // Reject before any data byte so a bad frame never touches memory.
            if (!range_ok(addr_q, full_count, ADDR_WIDTH, depth_sel)) begin
              err_d      = 1'b1;
              err_code_d = ErrRange;
              state_d    = StErr;
            end else if (full_count == 16'd0) begin
              state_d = StCsum;
            end else begin
              state_d = StData;
            end
          end
        end
      end
      StData: begin
        asm_valid = accept;
        if (accept && (asm_byte_cnt == 2'd3) && (word_idx_q == count_q - 16'd1)) begin
          state_d = StCsum;
        end
      end
      StCsum: begin
        if (accept) begin
          if (rx_data_i == asm_csum) begin
            state_d = StIdle;
          end else begin
            err_d      = 1'b1;
            err_code_d = ErrCsum;
            state_d    = StErr;
          end
        end
      end
      StDone, StErr: begin
        state_d = state_q;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      count_q     <= '0;
      field_cnt_q <= '0;
      word_idx_q  <= '0;
      sel_q       <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ErrNone;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      field_cnt_q <= field_cnt_d;
      word_idx_q  <= word_idx_d;
      sel_q       <= sel_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      run_q       <= run_d;
    end
  end

  assign mem_we_o    = asm_word_done;
  assign mem_sel_o   = sel_q;
  assign mem_addr_o  = addr_q[ADDR_WIDTH-1:0] + ADDR_WIDTH'(word_idx_q);
  assign mem_wdata_o = asm_word;
  assign cpu_run_o   = run_q;
  assign busy_o      = (state_q == StAddr) || (state_q == StCount) ||
                       (state_q == StData) || (state_q == StCsum);
  assign err_o       = err_q;
  assign err_code_o  = err_code_q;

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: streams frames and checks writes, errors and core release.
module tb_mem_loader;

  logic        clk;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        mem_we;
  logic        mem_sel;
  logic [14:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_run;
  logic        busy;
  logic        err;
  logic [1:0]  err_code;

  int vectors;
  int miscompares;
  int base;

  logic [14:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic        wr_sel[$];

  mem_loader #(
    .ADDR_WIDTH (15),
    .IMEM_WORDS (32768),
    .DMEM_WORDS (32768)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .rx_valid_i  (rx_valid),
    .rx_data_i   (rx_data),
    .rx_ready_o  (rx_ready),
    .mem_we_o    (mem_we),
    .mem_sel_o   (mem_sel),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .cpu_run_o   (cpu_run),
    .busy_o      (busy),
    .err_o       (err),
    .err_code_o  (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write log, sampled mid-cycle; the bench acts 1 time unit after each falling edge.
  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
      wr_sel.push_back(mem_sel);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic gap(input int n);
    rx_valid = 1'b0;
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic send_frame1(input logic [7:0] csum);
    logic [7:0] f [15];
    f = '{8'h01, 8'h10, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00,
          8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    for (int i = 0; i < 15; i++) put(f[i]);
    put(csum);
  endtask

  task automatic chk_frame1_writes(input string tag);
    chk({tag, "_nwr"}, 32'(wr_addr.size() - base), 32'd2);
    if (wr_addr.size() - base == 2) begin
      chk({tag, "_sel0"}, 32'(wr_sel[base]), 32'd0);
      chk({tag, "_addr0"}, 32'(wr_addr[base]), 32'h10);
      chk({tag, "_data0"}, wr_data[base], 32'h0000_0013);
      chk({tag, "_sel1"}, 32'(wr_sel[base+1]), 32'd0);
      chk({tag, "_addr1"}, 32'(wr_addr[base+1]), 32'h11);
      chk({tag, "_data1"}, wr_data[base+1], 32'h0010_0093);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    rx_valid    = 1'b0;
    rx_data     = 8'h00;
    repeat (2) @(negedge clk);
    #1;

    // Reset state
    chk("rst_ready", 32'(rx_ready), 32'd1);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_run", 32'(cpu_run), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_code", 32'(err_code), 32'd0);
    reset = 1'b0;

    // 1: good imem load
    base = wr_addr.size();
    put(8'h01);
    chk("t1_busy_after_cmd", 32'(busy), 32'd1);
    for (int i = 0; i < 6; i++) put((i == 0) ? 8'h10 : ((i == 4) ? 8'h02 : 8'h00));
    put(8'h13); put(8'h00); put(8'h00); put(8'h00);
    put(8'h93); put(8'h00); put(8'h10); put(8'h00);
    put(8'h90);
    chk_frame1_writes("t1");
    chk("t1_err", 32'(err), 32'd0);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_ready", 32'(rx_ready), 32'd1);

    // 2: checksum mismatch keeps the writes, then latches error
    do_reset();
    base = wr_addr.size();
    send_frame1(8'h91);
    chk("t2_nwr", 32'(wr_addr.size() - base), 32'd2);
    chk("t2_err", 32'(err), 32'd1);
    chk("t2_code", 32'(err_code), 32'd3);
    chk("t2_ready", 32'(rx_ready), 32'd0);

    // 3: range overflow by one word past the top
    do_reset();
    base = wr_addr.size();
    put(8'h02); put(8'hFF); put(8'h7F); put(8'h00); put(8'h00); put(8'h02);
    chk("t3_code_early", 32'(err_code), 32'd0);
    put(8'h00);
    chk("t3_code", 32'(err_code), 32'd2);
    chk("t3_err", 32'(err), 32'd1);
    put(8'h11); put(8'h22); put(8'h33); put(8'h44);
    gap(2);
    chk("t3_nwr", 32'(wr_addr.size() - base), 32'd0);

    // 3b: last word exactly at the top of dmem is legal
    do_reset();
    base = wr_addr.size();
    put(8'h02); put(8'hFF); put(8'h7F); put(8'h00); put(8'h00); put(8'h01); put(8'h00);
    put(8'hAA); put(8'hBB); put(8'hCC); put(8'hDD);
    put(8'h00);
    chk("t3b_err", 32'(err), 32'd0);
    chk("t3b_nwr", 32'(wr_addr.size() - base), 32'd1);
    if (wr_addr.size() - base == 1) begin
      chk("t3b_sel", 32'(wr_sel[base]), 32'd1);
      chk("t3b_addr", 32'(wr_addr[base]), 32'h7FFF);
      chk("t3b_data", wr_data[base], 32'hDDCC_BBAA);
    end

    // 3c: nonzero high address bits
    do_reset();
    put(8'h01); put(8'h00); put(8'h00); put(8'h01); put(8'h00); put(8'h01); put(8'h00);
    chk("t3c_code", 32'(err_code), 32'd2);

    // 4: load then RUN; trailing byte ignored
    do_reset();
    base = wr_addr.size();
    send_frame1(8'h90);
    chk("t4_run_pre", 32'(cpu_run), 32'd0);
    put(8'h03);
    chk("t4_run", 32'(cpu_run), 32'd1);
    chk("t4_ready", 32'(rx_ready), 32'd0);
    chk("t4_busy", 32'(busy), 32'd0);
    put(8'h01);
    gap(3);
    chk("t4_run_hold", 32'(cpu_run), 32'd1);
    chk("t4_err", 32'(err), 32'd0);
    chk("t4_nwr", 32'(wr_addr.size() - base), 32'd2);

    // 5: reset in the middle of a data word
    do_reset();
    base = wr_addr.size();
    put(8'h01); put(8'h10); put(8'h00); put(8'h00); put(8'h00); put(8'h01); put(8'h00);
    put(8'h13); put(8'h00);
    do_reset();
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_run", 32'(cpu_run), 32'd0);
    chk("t5_ready", 32'(rx_ready), 32'd1);
    gap(4);
    chk("t5_nwr", 32'(wr_addr.size() - base), 32'd0);
    send_frame1(8'h90);
    chk_frame1_writes("t5");
    chk("t5_err", 32'(err), 32'd0);

    // 6: empty frame with gaps, then an unknown command
    do_reset();
    base = wr_addr.size();
    for (int i = 0; i < 8; i++) begin
      put((i == 0) ? 8'h01 : 8'h00);
      gap($urandom_range(0, 3));
    end
    chk("t6_err", 32'(err), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_nwr", 32'(wr_addr.size() - base), 32'd0);
    put(8'h07);
    chk("t6_err_bad", 32'(err), 32'd1);
    chk("t6_code", 32'(err_code), 32'd1);
    chk("t6_ready", 32'(rx_ready), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
